// File: rtl/ddr3_avl_pkg.sv
// Shared types and widths for the DDR3 Avalon-MM two-port arbiter.
package ddr3_avl_pkg;

  localparam int AVL_ADDR_W = 26;
  localparam int AVL_DATA_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_CMD    = 2'd1,
    ARB_RDWAIT = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/ddr3_avl_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: with both ports requesting, the port
// not served last wins; a lone requester always wins.
module rr_pick2
  import ddr3_avl_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output logic       valid,
  output port_id_t   grant
);

  // Grant selection from the request vector and the last-served port
  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Shares the DDR3 controller Avalon-MM port between the buffer writer (port 0)
// and reader (port 1). Optional watchdog abort enabled by AVL_ARB_TIMEOUT_EN.
module ddr3_avl_arbiter
  import ddr3_avl_pkg::*;
#(
  parameter int ADDR_W         = AVL_ADDR_W,
  parameter int DATA_W         = AVL_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic              p0_write,
  input  logic              p0_read,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest_n,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic              p1_write,
  input  logic              p1_read,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest_n,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,
  output logic [ADDR_W-1:0] avl_address,
  output logic [DATA_W-1:0] avl_writedata,
  output logic              avl_write,
  output logic              avl_read,
  output logic              avl_burstbegin,
  output logic [2:0]        avl_size,
  input  logic              avl_waitrequest_n,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic              arb_timeout
);

  arb_state_t        state_r, state_nxt_s;
  port_id_t          grant_r, last_r, pick_s;
  logic              pick_vld_s;
  logic [1:0]        req_s;
  logic              avl_write_r, avl_read_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic              rdv0_r, rdv1_r;
  logic              accept_s, timeout_s;

  assign req_s = {p1_write | p1_read, p0_write | p0_read};

  rr_pick2 u_pick (
    .req   (req_s),
    .last  (last_r),
    .valid (pick_vld_s),
    .grant (pick_s)
  );

  assign accept_s = (state_r == ARB_CMD) & avl_waitrequest_n;

`ifdef AVL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog: restarts on every state change, counts while busy
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_nxt_s != state_r) || (state_r == ARB_IDLE)) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end
  end

  // A completion in the final cycle takes priority over the abort
  assign timeout_s = (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) &
                     (((state_r == ARB_CMD) & ~avl_waitrequest_n) |
                      ((state_r == ARB_RDWAIT) & ~avl_readdatavalid));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_vld_s) state_nxt_s = ARB_CMD;
        else            state_nxt_s = ARB_IDLE;
      end
      ARB_CMD: begin
        if (accept_s)       state_nxt_s = avl_read_r ? ARB_RDWAIT : ARB_IDLE;
        else if (timeout_s) state_nxt_s = ARB_IDLE;
        else                state_nxt_s = ARB_CMD;
      end
      ARB_RDWAIT: begin
        if (avl_readdatavalid || timeout_s) state_nxt_s = ARB_IDLE;
        else                                state_nxt_s = ARB_RDWAIT;
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) state_r <= ARB_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Command latch, grant pointer and read-return registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      grant_r     <= 1'b0;
      last_r      <= 1'b1;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      avl_write_r <= 1'b0;
      avl_read_r  <= 1'b0;
      rdv0_r      <= 1'b0;
      rdv1_r      <= 1'b0;
    end else begin
      rdv0_r <= 1'b0;
      rdv1_r <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (pick_vld_s) begin
            grant_r     <= pick_s;
            last_r      <= pick_s;
            addr_r      <= pick_s ? p1_address : p0_address;
            wdata_r     <= pick_s ? p1_writedata : p0_writedata;
            // write wins when a port raises both commands
            avl_write_r <= pick_s ? p1_write : p0_write;
            avl_read_r  <= pick_s ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
          end
        end
        ARB_CMD: begin
          if (accept_s || timeout_s) begin
            avl_write_r <= 1'b0;
            avl_read_r  <= 1'b0;
          end
        end
        ARB_RDWAIT: begin
          if (avl_readdatavalid) begin
            rdata_r <= avl_readdata;
            rdv0_r  <= ~grant_r;
            rdv1_r  <= grant_r;
          end
        end
        default: begin
          avl_write_r <= 1'b0;
          avl_read_r  <= 1'b0;
        end
      endcase
    end
  end

  assign p0_waitrequest_n = accept_s & ~grant_r;
  assign p1_waitrequest_n = accept_s & grant_r;
  assign p0_readdata      = rdata_r;
  assign p1_readdata      = rdata_r;
  assign p0_readdatavalid = rdv0_r;
  assign p1_readdatavalid = rdv1_r;
  assign avl_address      = addr_r;
  assign avl_writedata    = wdata_r;
  assign avl_write        = avl_write_r;
  assign avl_read         = avl_read_r;
  assign avl_burstbegin   = avl_write_r | avl_read_r;
  assign avl_size         = 3'd1;
  assign arb_timeout      = timeout_s;

endmodule
